vertex_dispatch: RTL and testbench

VERTEX_DISPATCH -- requirements
Module: vertex_dispatch

---
 rtl/vertex_dispatch.sv | 176 +++++++++++++++++
 tb/tb_vertex_dispatch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_dispatch.sv
// vertex_dispatch: feeds a batch of vertices one at a time through an external transform unit.
// Optional DONE watchdog is compiled in with `define VERTEX_DISPATCH_TIMEOUT_EN.

module vertex_dispatch #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              GO,
  input  logic [ADDR_W-1:0] VCOUNT,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [31:0]       RD_X,
  input  logic [31:0]       RD_Y,
  input  logic [31:0]       RD_Z,
  output logic [31:0]       x,
  output logic [31:0]       y,
  output logic [31:0]       z,
  output logic              STARTER,
  input  logic              DONE,
  input  logic [31:0]       newx,
  input  logic [31:0]       newy,
  input  logic [31:0]       newz,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_X,
  output logic [31:0]       WR_Y,
  output logic [31:0]       WR_Z,
  output logic              BUSY,
  output logic              FINISHED,
  output logic              ERR
);

`ifdef VERTEX_DISPATCH_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam int WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT,
    S_WRITE,
    S_END
  } stateT;

  stateT             r_state;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_rdAddr;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [31:0]       r_x, r_y, r_z;
  logic [31:0]       r_wrX, r_wrY, r_wrZ;
  logic              r_starter;
  logic              r_wrEn;
  logic              r_busy;
  logic              r_finished;
  logic              r_err;
  logic [WaitW-1:0]  r_waitCnt;
  logic [ADDR_W-1:0] w_nextIndex;

  // The last index processed is at most 2^ADDR_W-2, so this increment cannot wrap.
  assign w_nextIndex = r_index + ADDR_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_count    <= '0;
      r_rdAddr   <= '0;
      r_wrAddr   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_wrX      <= '0;
      r_wrY      <= '0;
      r_wrZ      <= '0;
      r_starter  <= 1'b0;
      r_wrEn     <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_err      <= 1'b0;
      r_waitCnt  <= '0;
    end else begin
      r_starter  <= 1'b0;
      r_wrEn     <= 1'b0;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (GO) begin
            r_err   <= 1'b0;
            r_index <= '0;
            r_count <= VCOUNT;
            r_busy  <= 1'b1;
            if (VCOUNT != '0) begin
              r_rdAddr <= '0;
              r_state  <= S_FETCH;
            end else begin
              r_finished <= 1'b1;
              r_state    <= S_END;
            end
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        // Source memory returns data one cycle after RD_ADDR, i.e. during LOAD.
        S_LOAD: begin
          r_x       <= RD_X;
          r_y       <= RD_Y;
          r_z       <= RD_Z;
          r_starter <= 1'b1;
          r_state   <= S_START;
        end
        S_START: begin
          r_waitCnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (DONE) begin
            r_wrX    <= newx;
            r_wrY    <= newy;
            r_wrZ    <= newz;
            r_wrAddr <= r_index;
            r_wrEn   <= 1'b1;
            r_state  <= S_WRITE;
          end else if (TimeoutEn && (r_waitCnt == WaitW'(TIMEOUT - 1))) begin
            r_err      <= 1'b1;
            r_finished <= 1'b1;
            r_state    <= S_END;
          end else begin
            r_waitCnt <= r_waitCnt + WaitW'(1);
          end
        end
        S_WRITE: begin
          r_index <= w_nextIndex;
          if (w_nextIndex < r_count) begin
            r_rdAddr <= w_nextIndex;
            r_state  <= S_FETCH;
          end else begin
            r_finished <= 1'b1;
            r_state    <= S_END;
          end
        end
        S_END: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign RD_ADDR  = r_rdAddr;
  assign x        = r_x;
  assign y        = r_y;
  assign z        = r_z;
  assign STARTER  = r_starter;
  assign WR_EN    = r_wrEn;
  assign WR_ADDR  = r_wrAddr;
  assign WR_X     = r_wrX;
  assign WR_Y     = r_wrY;
  assign WR_Z     = r_wrZ;
  assign BUSY     = r_busy;
  assign FINISHED = r_finished;
  assign ERR      = TimeoutEn & r_err;

endmodule

// File: tb/tb_vertex_dispatch.sv
// tb_vertex_dispatch: directed batches against a batch-level model of vertex_dispatch.
// Define VERTEX_DISPATCH_TIMEOUT_EN to also exercise the DONE watchdog.

module tb_vertex_dispatch;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              GO;
  logic [ADDR_W-1:0] VCOUNT;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [31:0]       RD_X, RD_Y, RD_Z;
  logic [31:0]       x, y, z;
  logic              STARTER;
  logic              DONE;
  logic [31:0]       newx, newy, newz;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [31:0]       WR_X, WR_Y, WR_Z;
  logic              BUSY;
  logic              FINISHED;
  logic              ERR;

  vertex_dispatch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .GO(GO), .VCOUNT(VCOUNT),
    .RD_ADDR(RD_ADDR), .RD_X(RD_X), .RD_Y(RD_Y), .RD_Z(RD_Z),
    .x(x), .y(y), .z(z), .STARTER(STARTER), .DONE(DONE),
    .newx(newx), .newy(newy), .newz(newz),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_X(WR_X), .WR_Y(WR_Y), .WR_Z(WR_Z),
    .BUSY(BUSY), .FINISHED(FINISHED), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Model state: what the current batch must still produce.
  bit batchActive = 1'b0;
  bit inVertex = 1'b0;
  bit errExp = 1'b0;
  bit timeoutMode = 1'b0;
  bit glitchMode = 1'b0;
  bit neverDone = 1'b0;
  int expCount = 0;
  int expIdx = 0;
  int doneDelay = 2;
  int goCyc = 0;
  int finCyc = 0;
  int starterCyc = 0;
  int starterCount = 0;
  int writeCount = 0;

  function automatic logic [31:0] srcX(input int i); return 32'h1000_0000 + 32'(i); endfunction
  function automatic logic [31:0] srcY(input int i); return 32'h2000_0000 + 32'(i * 16); endfunction
  function automatic logic [31:0] srcZ(input int i); return 32'h3000_0000 + 32'(i); endfunction
  function automatic logic [31:0] xfX(input logic [31:0] v); return v + 32'h0000_0100; endfunction
  function automatic logic [31:0] xfY(input logic [31:0] v); return v ^ 32'h0F0F_0F0F; endfunction
  function automatic logic [31:0] xfZ(input logic [31:0] v); return v << 1; endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Source memory with one cycle of read latency.
  initial begin
    logic [ADDR_W-1:0] rdPrev;
    rdPrev = '0;
    RD_X = '0; RD_Y = '0; RD_Z = '0;
    forever begin
      @(negedge CLK);
      RD_X = srcX(int'(rdPrev));
      RD_Y = srcY(int'(rdPrev));
      RD_Z = srcZ(int'(rdPrev));
      rdPrev = RD_ADDR;
    end
  end

  // Transform unit: DONE pulses doneDelay cycles after STARTER.
  initial begin
    int pending;
    pending = 0;
    DONE = 1'b0; newx = '0; newy = '0; newz = '0;
    forever begin
      @(negedge CLK);
      DONE = 1'b0; newx = '0; newy = '0; newz = '0;
      if (!RESET_N) begin
        pending = 0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            DONE = 1'b1;
            newx = xfX(x); newy = xfY(y); newz = xfZ(z);
          end
        end
        if (STARTER) begin
          pending = neverDone ? 0 : doneDelay;
          if (glitchMode) begin
            DONE = 1'b1;
            newx = 32'hDEAD_BEEF; newy = 32'hDEAD_BEEF; newz = 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  // Compare process: checks every cycle against the batch model.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        checkOutput("rst_ctrl", {27'b0, STARTER, WR_EN, FINISHED, BUSY, ERR}, 32'h0);
        checkOutput("rst_addr", {16'b0, RD_ADDR, WR_ADDR}, 32'h0);
        checkOutput("rst_xyz", x | y | z, 32'h0);
        checkOutput("rst_wr", WR_X | WR_Y | WR_Z, 32'h0);
        batchActive = 1'b0;
        inVertex = 1'b0;
        errExp = 1'b0;
      end else begin
        if (FINISHED && timeoutMode) errExp = 1'b1;
        checkOutput("busy", 32'(BUSY), 32'(batchActive));
        checkOutput("err", 32'(ERR), 32'(errExp));
        if (STARTER) begin
          checkOutput("starter_ok", 32'(batchActive && !inVertex && expIdx < expCount), 32'h1);
          checkOutput("x_at_start", x, srcX(expIdx));
          checkOutput("y_at_start", y, srcY(expIdx));
          checkOutput("z_at_start", z, srcZ(expIdx));
          starterCyc = cyc;
          inVertex = 1'b1;
          starterCount++;
        end else if (inVertex) begin
          checkOutput("xyz_hold", x ^ y ^ z, srcX(expIdx) ^ srcY(expIdx) ^ srcZ(expIdx));
        end
        if (WR_EN) begin
          checkOutput("wr_ok", 32'(inVertex && !timeoutMode), 32'h1);
          checkOutput("wr_addr", 32'(WR_ADDR), 32'(expIdx));
          checkOutput("wr_x", WR_X, xfX(srcX(expIdx)));
          checkOutput("wr_y", WR_Y, xfY(srcY(expIdx)));
          checkOutput("wr_z", WR_Z, xfZ(srcZ(expIdx)));
          checkOutput("wr_latency", 32'(cyc - starterCyc), 32'(doneDelay + 1));
          expIdx++;
          inVertex = 1'b0;
          writeCount++;
        end
        if (FINISHED) begin
          checkOutput("fin_ok", 32'(batchActive), 32'h1);
          checkOutput("fin_writes", 32'(expIdx), timeoutMode ? 32'h0 : 32'(expCount));
          checkOutput("fin_cycle", 32'(cyc - goCyc),
                      timeoutMode ? 32'(3 + TIMEOUT) : 32'(expCount * (4 + doneDelay)));
          finCyc = cyc;
          batchActive = 1'b0;
          inVertex = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int count);
    @(negedge CLK);
    GO = 1'b1;
    VCOUNT = ADDR_W'(count);
    @(posedge CLK);
    #1;
    GO = 1'b0;
    goCyc = cyc;
    expCount = count;
    expIdx = 0;
    inVertex = 1'b0;
    errExp = 1'b0;
    batchActive = 1'b1;
  endtask

  task automatic waitFinish(input int budget);
    int n;
    n = 0;
    while (batchActive && n < budget) begin
      @(posedge CLK);
      n++;
    end
    checkOutput("batch_done_in_budget", 32'(batchActive), 32'h0);
    batchActive = 1'b0;
    #2;
  endtask

  initial begin
    int s0, w0, n;
    RESET_N = 1'b0;
    GO = 1'b0;
    VCOUNT = '0;
    repeat (2) @(posedge CLK);
    #2;
    checkOutput("reset_busy", 32'(BUSY), 32'h0);
    checkOutput("reset_pulses", {29'b0, STARTER, WR_EN, FINISHED}, 32'h0);
    checkOutput("reset_rdaddr", 32'(RD_ADDR), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] three-vertex batch, DONE two cycles after STARTER");
    doneDelay = 2; s0 = starterCount; w0 = writeCount;
    applyStimulus(3);
    waitFinish(200);
    checkOutput("b3_latency", 32'(finCyc - goCyc), 32'd18);
    checkOutput("b3_starters", 32'(starterCount - s0), 32'd3);
    checkOutput("b3_writes", 32'(writeCount - w0), 32'd3);
    checkOutput("b3_last_addr", 32'(WR_ADDR), 32'd2);
    checkOutput("b3_last_wrx", WR_X, 32'h1000_0102);
    checkOutput("b3_last_wry", WR_Y, 32'h2F0F_0F2F);
    checkOutput("b3_last_wrz", WR_Z, 32'h6000_0004);
    checkOutput("b3_last_x", x, 32'h1000_0002);

    $display("[TB] empty batch");
    s0 = starterCount; w0 = writeCount;
    applyStimulus(0);
    waitFinish(20);
    checkOutput("b0_latency", 32'(finCyc - goCyc), 32'd0);
    checkOutput("b0_starters", 32'(starterCount - s0), 32'd0);
    checkOutput("b0_writes", 32'(writeCount - w0), 32'd0);

    $display("[TB] DONE high during START, real DONE six cycles later");
    glitchMode = 1'b1; doneDelay = 6; w0 = writeCount;
    applyStimulus(2);
    waitFinish(200);
    glitchMode = 1'b0;
    checkOutput("glitch_latency", 32'(finCyc - goCyc), 32'd20);
    checkOutput("glitch_writes", 32'(writeCount - w0), 32'd2);
    checkOutput("glitch_last_wrx", WR_X, 32'h1000_0101);

    $display("[TB] GO and VCOUNT disturbed mid-batch");
    doneDelay = 1; s0 = starterCount; w0 = writeCount;
    applyStimulus(3);
    repeat (2) @(negedge CLK);
    GO = 1'b1; VCOUNT = 8'd7;
    repeat (3) @(negedge CLK);
    GO = 1'b0;
    waitFinish(200);
    checkOutput("dist_latency", 32'(finCyc - goCyc), 32'd15);
    checkOutput("dist_starters", 32'(starterCount - s0), 32'd3);
    checkOutput("dist_writes", 32'(writeCount - w0), 32'd3);
    repeat (4) @(negedge CLK);
    checkOutput("dist_no_restart", 32'(BUSY), 32'h0);

    $display("[TB] reset while waiting on vertex 1");
    doneDelay = 30; s0 = starterCount; w0 = writeCount;
    applyStimulus(3);
    n = 0;
    while (starterCount < s0 + 2 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    checkOutput("rst_reached_v1", 32'(starterCount - s0), 32'd2);
    repeat (3) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    checkOutput("midrst_ctrl", {27'b0, STARTER, WR_EN, FINISHED, BUSY, ERR}, 32'h0);
    checkOutput("midrst_addr", {16'b0, RD_ADDR, WR_ADDR}, 32'h0);
    checkOutput("midrst_x", x, 32'h0);
    checkOutput("midrst_wrx", WR_X, 32'h0);
    checkOutput("midrst_writes", 32'(writeCount - w0), 32'd1);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    doneDelay = 2; w0 = writeCount;
    applyStimulus(2);
    waitFinish(200);
    checkOutput("post_rst_latency", 32'(finCyc - goCyc), 32'd12);
    checkOutput("post_rst_writes", 32'(writeCount - w0), 32'd2);
    checkOutput("post_rst_last_addr", 32'(WR_ADDR), 32'd1);

`ifdef VERTEX_DISPATCH_TIMEOUT_EN
    $display("[TB] DONE never returns, watchdog expected");
    neverDone = 1'b1; timeoutMode = 1'b1; w0 = writeCount;
    applyStimulus(1);
    waitFinish(200);
    checkOutput("to_latency", 32'(finCyc - goCyc), 32'd19);
    checkOutput("to_err", 32'(ERR), 32'h1);
    checkOutput("to_writes", 32'(writeCount - w0), 32'd0);
    neverDone = 1'b0; timeoutMode = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("to_err_sticky", 32'(ERR), 32'h1);
    doneDelay = 2;
    applyStimulus(1);
    checkOutput("to_err_cleared", 32'(ERR), 32'h0);
    waitFinish(200);
`endif

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
